// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared types and constants for the Thumb prefetch path
package fetch_pkg;

    typedef logic [15:0] hword_t;

    typedef enum logic [1:0] {
        TAKE0,
        TAKE1,
        TAKE2
    } consume_t;

    localparam hword_t THUMB_NOP = 16'hBF00;

endpackage

// File: rtl/hw_ring_buffer.sv
// rtl/hw_ring_buffer.sv - halfword ring with 0/1/2 write and read per cycle
module hw_ring_buffer
    import fetch_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clear,
    input  logic [1:0]                   wr_n,
    input  hword_t                       wr_data0,
    input  hword_t                       wr_data1,
    input  logic [1:0]                   rd_n,
    output hword_t                       rd_data0,
    output hword_t                       rd_data1,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    hword_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head_p1;
    logic [PTR_W-1:0] tail_p1;

    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    assign head_p1  = head + PTR_W'(1);
    assign tail_p1  = tail + PTR_W'(1);
    assign rd_data0 = mem[head];
    assign rd_data1 = mem[head_p1];

    // Pointers and occupancy; the caller guarantees rd_n <= count and wr_n fits.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(rd_n);
            tail  <= tail + PTR_W'(wr_n);
            count <= count - CNT_W'(rd_n) + CNT_W'(wr_n);
        end
    end

    // Storage is never reset; a two-halfword write at tail=DEPTH-1 lands its
    // second halfword at index 0 through tail_p1 wrapping.
    always_ff @(posedge clk) begin
        if (!rst && !clear) begin
            if (wr_n != 2'd0) begin
                mem[tail] <= wr_data0;
            end
            if (wr_n == 2'd2) begin
                mem[tail_p1] <= wr_data1;
            end
        end
    end

endmodule

// File: rtl/thumb_prefetch_queue.sv
// rtl/thumb_prefetch_queue.sv - dual-bank ROM prefetch queue feeding the Thumb decoder
module thumb_prefetch_queue
    import fetch_pkg::*;
#(
    parameter int ADDR_W = 14,
    parameter int DEPTH  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic [ADDR_W-1:0] flush_addr,
    output logic [ADDR_W-2:0] rom_addr,
    input  logic [15:0]       rom_even,
    input  logic [15:0]       rom_odd,
    output logic [15:0]       ir_0,
    output logic [15:0]       ir_1,
    output logic              ir0_valid,
    output logic              ir1_valid,
    output logic [ADDR_W-1:0] pc_0,
    input  logic [1:0]        consume
);

    localparam int CNT_W = $clog2(DEPTH+1);

    logic [ADDR_W-1:0] fpc;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  room;
    logic [1:0]        enq_n;
    logic [1:0]        eff;
    hword_t            wr0;
    hword_t            wr1;

    assign room      = CNT_W'(DEPTH) - count;
    assign rom_addr  = fpc[ADDR_W-1:1];
    assign ir0_valid = (count >= CNT_W'(1));
    assign ir1_valid = (count >= CNT_W'(2));

    // Fetch decision from the registered count only; an odd fpc fetches just
    // the upper halfword so the next fetch is word aligned.
    always_comb begin
        enq_n = 2'd0;
        wr0   = rom_even;
        wr1   = rom_odd;
        if (!flush) begin
            if (!fpc[0] && room >= CNT_W'(2)) begin
                enq_n = 2'd2;
            end else if (fpc[0] && room >= CNT_W'(1)) begin
                enq_n = 2'd1;
                wr0   = rom_odd;
            end
        end
    end

    // Clamp the decoder's consume request to what is actually valid.
    always_comb begin
        eff = 2'd0;
        if (!flush) begin
            if (consume >= 2'(TAKE2) && count >= CNT_W'(2)) begin
                eff = 2'd2;
            end else if (consume != 2'(TAKE0) && count >= CNT_W'(1)) begin
                eff = 2'd1;
            end
        end
    end

    // Fetch and issue program counters; reset beats flush, flush beats advance.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpc  <= '0;
            pc_0 <= '0;
        end else if (flush) begin
            fpc  <= flush_addr;
            pc_0 <= flush_addr;
        end else begin
            fpc  <= fpc + ADDR_W'(enq_n);
            pc_0 <= pc_0 + ADDR_W'(eff);
        end
    end

    hw_ring_buffer #(
        .DEPTH(DEPTH)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .clear    (flush),
        .wr_n     (enq_n),
        .wr_data0 (wr0),
        .wr_data1 (wr1),
        .rd_n     (eff),
        .rd_data0 (ir_0),
        .rd_data1 (ir_1),
        .count    (count)
    );

endmodule

// File: tb/tb_thumb_prefetch_queue.sv
// tb/tb_thumb_prefetch_queue.sv - directed self-checking bench for thumb_prefetch_queue
module tb_thumb_prefetch_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [13:0] flush_addr;
    logic [12:0] rom_addr;
    logic [15:0] rom_even;
    logic [15:0] rom_odd;
    logic [15:0] ir_0;
    logic [15:0] ir_1;
    logic        ir0_valid;
    logic        ir1_valid;
    logic [13:0] pc_0;
    logic [1:0]  consume;

    int checks   = 0;
    int failures = 0;
    int viol     = 0;

    always #5 clk = ~clk;

    // ROM model: halfword address a returns 16'h2000 | a
    always_comb begin
        rom_even = 16'h2000 | {2'b00, rom_addr, 1'b0};
        rom_odd  = 16'h2000 | {2'b00, rom_addr, 1'b1};
    end

    // Decoder contract monitor: consume must not exceed the valid count
    always @(posedge clk) begin
        if (!rst && !flush && ((consume >= 2'd2 && !ir1_valid) || (consume != 2'd0 && !ir0_valid)))
            viol <= viol + 1;
    end

    thumb_prefetch_queue #(.ADDR_W(14), .DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .flush_addr (flush_addr),
        .rom_addr   (rom_addr),
        .rom_even   (rom_even),
        .rom_odd    (rom_odd),
        .ir_0       (ir_0),
        .ir_1       (ir_1),
        .ir0_valid  (ir0_valid),
        .ir1_valid  (ir1_valid),
        .pc_0       (pc_0),
        .consume    (consume)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; flush = 1'b0; flush_addr = '0; consume = 2'd0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; flush = 1'b0; flush_addr = '0; consume = 2'd0;
        step();
        step();
        checks++; if (ir0_valid !== 1'b0) begin failures++; $display("FAIL reset_v0 got=%b exp=0", ir0_valid); end
        checks++; if (ir1_valid !== 1'b0) begin failures++; $display("FAIL reset_v1 got=%b exp=0", ir1_valid); end
        checks++; if (pc_0 !== 14'd0) begin failures++; $display("FAIL reset_pc0 got=%0d exp=0", pc_0); end
        checks++; if (rom_addr !== 13'd0) begin failures++; $display("FAIL reset_rom_addr got=%0d exp=0", rom_addr); end
        rst = 1'b0;
    endtask

    task automatic test_fill_stall();
        do_reset();
        step();
        checks++; if (ir0_valid !== 1'b1) begin failures++; $display("FAIL fill_first_v0 got=%b exp=1", ir0_valid); end
        checks++; if (rom_addr !== 13'd1) begin failures++; $display("FAIL fill_rom_addr1 got=%0d exp=1", rom_addr); end
        step(); step(); step();
        checks++; if (rom_addr !== 13'd4) begin failures++; $display("FAIL fill_rom_addr4 got=%0d exp=4", rom_addr); end
        step(); step(); step(); step();
        checks++; if (rom_addr !== 13'd4) begin failures++; $display("FAIL stall_rom_addr got=%0d exp=4", rom_addr); end
        checks++; if (ir_0 !== 16'h2000) begin failures++; $display("FAIL stall_ir0 got=%h exp=2000", ir_0); end
        checks++; if (ir_1 !== 16'h2001) begin failures++; $display("FAIL stall_ir1 got=%h exp=2001", ir_1); end
        checks++; if (pc_0 !== 14'd0) begin failures++; $display("FAIL stall_pc0 got=%0d exp=0", pc_0); end
        checks++; if (ir1_valid !== 1'b1) begin failures++; $display("FAIL stall_v1 got=%b exp=1", ir1_valid); end
    endtask

    task automatic test_steady();
        logic [13:0] e;
        do_reset();
        step();
        consume = 2'd2;
        for (int i = 0; i < 8; i++) begin
            e = 14'(2 * i);
            checks++; if (pc_0 !== e) begin failures++; $display("FAIL steady_pc0[%0d] got=%0d exp=%0d", i, pc_0, e); end
            checks++; if ({ir0_valid, ir1_valid} !== 2'b11) begin failures++; $display("FAIL steady_valid[%0d] got=%b%b exp=11", i, ir0_valid, ir1_valid); end
            checks++; if (ir_0 !== (16'h2000 | {2'b00, e})) begin failures++; $display("FAIL steady_ir0[%0d] got=%h exp=%h", i, ir_0, 16'h2000 | {2'b00, e}); end
            checks++; if (ir_1 !== (16'h2001 | {2'b00, e})) begin failures++; $display("FAIL steady_ir1[%0d] got=%h exp=%h", i, ir_1, 16'h2001 | {2'b00, e}); end
            step();
        end
        consume = 2'd0;
    endtask

    task automatic test_flush();
        do_reset();
        step(); step(); step(); step(); step();
        flush = 1'b1; flush_addr = 14'd5;
        step();
        flush = 1'b0;
        checks++; if (ir0_valid !== 1'b0) begin failures++; $display("FAIL flush_empty got=%b exp=0", ir0_valid); end
        checks++; if (rom_addr !== 13'd2) begin failures++; $display("FAIL flush_rom_addr got=%0d exp=2", rom_addr); end
        checks++; if (pc_0 !== 14'd5) begin failures++; $display("FAIL flush_pc0 got=%0d exp=5", pc_0); end
        step();
        checks++; if (ir0_valid !== 1'b1) begin failures++; $display("FAIL flush_v0 got=%b exp=1", ir0_valid); end
        checks++; if (ir1_valid !== 1'b0) begin failures++; $display("FAIL flush_v1 got=%b exp=0", ir1_valid); end
        checks++; if (ir_0 !== 16'h2005) begin failures++; $display("FAIL flush_ir0 got=%h exp=2005", ir_0); end
        step();
        checks++; if (ir1_valid !== 1'b1) begin failures++; $display("FAIL flush_v1b got=%b exp=1", ir1_valid); end
        checks++; if (ir_0 !== 16'h2005) begin failures++; $display("FAIL flush_ir0b got=%h exp=2005", ir_0); end
        checks++; if (ir_1 !== 16'h2006) begin failures++; $display("FAIL flush_ir1 got=%h exp=2006", ir_1); end
    endtask

    task automatic test_clamp();
        int v0;
        do_reset();
        step();
        flush = 1'b1; flush_addr = 14'd5;
        step();
        flush = 1'b0;
        step();
        v0 = viol;
        consume = 2'd2;
        step();
        consume = 2'd0;
        checks++; if (pc_0 !== 14'd6) begin failures++; $display("FAIL clamp_pc0 got=%0d exp=6", pc_0); end
        checks++; if (ir1_valid !== 1'b1) begin failures++; $display("FAIL clamp_v1 got=%b exp=1", ir1_valid); end
        checks++; if (ir_0 !== 16'h2006) begin failures++; $display("FAIL clamp_ir0 got=%h exp=2006", ir_0); end
        checks++; if (ir_1 !== 16'h2007) begin failures++; $display("FAIL clamp_ir1 got=%h exp=2007", ir_1); end
        checks++; if (viol - v0 !== 1) begin failures++; $display("FAIL clamp_violation got=%0d exp=1", viol - v0); end
    endtask

    task automatic test_wrap();
        logic [13:0] e;
        consume = 2'd0;
        flush = 1'b1; flush_addr = 14'd16383;
        step();
        flush = 1'b0;
        checks++; if (rom_addr !== 13'd8191) begin failures++; $display("FAIL wrap_rom_addr got=%0d exp=8191", rom_addr); end
        checks++; if (pc_0 !== 14'd16383) begin failures++; $display("FAIL wrap_pc0_start got=%0d exp=16383", pc_0); end
        step();
        checks++; if (rom_addr !== 13'd0) begin failures++; $display("FAIL wrap_fpc got=%0d exp=0", rom_addr); end
        for (int i = 0; i < 10; i++) begin
            e = 14'd16383 + 14'(i);
            checks++; if (pc_0 !== e) begin failures++; $display("FAIL wrap_pc0[%0d] got=%0d exp=%0d", i, pc_0, e); end
            checks++; if (ir0_valid !== 1'b1) begin failures++; $display("FAIL wrap_v0[%0d] got=%b exp=1", i, ir0_valid); end
            checks++; if (ir_0 !== (16'h2000 | {2'b00, e})) begin failures++; $display("FAIL wrap_ir0[%0d] got=%h exp=%h", i, ir_0, 16'h2000 | {2'b00, e}); end
            if (ir1_valid) begin
                checks++; if (ir_1 !== (16'h2000 | {2'b00, e + 14'd1})) begin failures++; $display("FAIL wrap_ir1[%0d] got=%h exp=%h", i, ir_1, 16'h2000 | {2'b00, e + 14'd1}); end
            end
            consume = 2'd1;
            step();
        end
        consume = 2'd0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        step();
        consume = 2'd2;
        step(); step(); step();
        rst = 1'b1; flush = 1'b1; flush_addr = 14'd5;
        step();
        checks++; if (pc_0 !== 14'd0) begin failures++; $display("FAIL rstmid_pc0 got=%0d exp=0", pc_0); end
        checks++; if (rom_addr !== 13'd0) begin failures++; $display("FAIL rstmid_rom_addr got=%0d exp=0", rom_addr); end
        checks++; if ({ir0_valid, ir1_valid} !== 2'b00) begin failures++; $display("FAIL rstmid_valid got=%b%b exp=00", ir0_valid, ir1_valid); end
        rst = 1'b0; flush = 1'b0; consume = 2'd0;
        step();
        checks++; if (ir0_valid !== 1'b1) begin failures++; $display("FAIL rstmid_v0 got=%b exp=1", ir0_valid); end
        checks++; if (ir_0 !== 16'h2000) begin failures++; $display("FAIL rstmid_ir0 got=%h exp=2000", ir_0); end
        checks++; if (pc_0 !== 14'd0) begin failures++; $display("FAIL rstmid_pc0b got=%0d exp=0", pc_0); end
        checks++; if (rom_addr !== 13'd1) begin failures++; $display("FAIL rstmid_rom_addr1 got=%0d exp=1", rom_addr); end
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; flush_addr = '0; consume = 2'd0;
        test_reset();
        test_fill_stall();
        test_steady();
        test_flush();
        test_clamp();
        test_wrap();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
